// File: rtl/regfile_wr_pkg.sv
// Shared types and default widths for the register-file write-port arbiter.
package regfile_wr_pkg;

    localparam int ADDR_W_DFLT = 5;
    localparam int DATA_W_DFLT = 32;

    typedef enum logic {
        NORMAL  = 1'b0,
        FAVOR_B = 1'b1
    } arb_state_t;

    // One writeback entry at the default widths.
    typedef struct packed {
        logic                   valid;
        logic [ADDR_W_DFLT-1:0] addr;
        logic [DATA_W_DFLT-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_skid_buf.sv
// One-entry writeback buffer: captures on valid&ready, empties when granted.
// Ready also asserts when the entry is granted this cycle, allowing one transfer per cycle.
module wb_skid_buf
    import regfile_wr_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int DATA_W = DATA_W_DFLT
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              grant,
    output logic              ready,
    output logic              valid,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    logic              valid_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] data_r;

    assign ready = ~RESET & (~valid_r | grant);
    assign valid = valid_r;
    assign addr  = addr_r;
    assign data  = data_r;

    // Entry storage: a refill on the granting edge replaces the old entry.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_r <= 1'b0;
            addr_r  <= '0;
            data_r  <= '0;
        end else if (in_valid && ready) begin
            valid_r <= 1'b1;
            addr_r  <= in_addr;
            data_r  <= in_data;
        end else if (grant) begin
            valid_r <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the register file's single write port between ALU (A) and load (B) writeback.
// Optional macro RWARB_BYPASS_EN adds a read-bypass lookup into the pending buffers.
module regfile_wr_arbiter
    import regfile_wr_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DFLT,
    parameter int ADDR_W   = ADDR_W_DFLT,
    parameter int MAX_WAIT = 4
) (
    input  logic              CLK,
    input  logic              RESET,
`ifdef RWARB_BYPASS_EN
    input  logic [ADDR_W-1:0] RD_ADDR,
    output logic              RD_HIT,
    output logic [DATA_W-1:0] RD_DATA,
`endif
    input  logic              A_VALID,
    output logic              A_READY,
    input  logic [ADDR_W-1:0] A_ADDR,
    input  logic [DATA_W-1:0] A_DATA,
    input  logic              B_VALID,
    output logic              B_READY,
    input  logic [ADDR_W-1:0] B_ADDR,
    input  logic [DATA_W-1:0] B_DATA,
    output logic              WRITE,
    output logic [ADDR_W-1:0] INADDRESS,
    output logic [DATA_W-1:0] IN,
    output logic              BUSY
);

    logic              a_valid_s;
    logic [ADDR_W-1:0] a_addr_s;
    logic [DATA_W-1:0] a_data_s;
    logic              b_valid_s;
    logic [ADDR_W-1:0] b_addr_s;
    logic [DATA_W-1:0] b_data_s;
    logic              grant_a_s;
    logic              grant_b_s;
    logic              collide_s;
    arb_state_t        state_r;
    arb_state_t        state_nxt_s;
    logic [3:0]        wait_r;
    logic [3:0]        wait_nxt_s;

    wb_skid_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_buf_a (
        .CLK      (CLK),
        .RESET    (RESET),
        .in_valid (A_VALID),
        .in_addr  (A_ADDR),
        .in_data  (A_DATA),
        .grant    (grant_a_s),
        .ready    (A_READY),
        .valid    (a_valid_s),
        .addr     (a_addr_s),
        .data     (a_data_s)
    );

    wb_skid_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_buf_b (
        .CLK      (CLK),
        .RESET    (RESET),
        .in_valid (B_VALID),
        .in_addr  (B_ADDR),
        .in_data  (B_DATA),
        .grant    (grant_b_s),
        .ready    (B_READY),
        .valid    (b_valid_s),
        .addr     (b_addr_s),
        .data     (b_data_s)
    );

    // Same-register pair: the older load must land first so A's value survives.
    assign collide_s = a_valid_s & b_valid_s & (a_addr_s == b_addr_s) & (a_addr_s != '0);
    assign grant_b_s = ~RESET & b_valid_s & (~a_valid_s | collide_s | (state_r == FAVOR_B));
    assign grant_a_s = ~RESET & a_valid_s & ~grant_b_s;
    assign BUSY      = ~RESET & (a_valid_s | b_valid_s);

    // Arbitration state and starvation counter.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= NORMAL;
            wait_r  <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            wait_r  <= wait_nxt_s;
        end
    end

    // Next state: a B loss at MAX_WAIT-1 forces B's next grant.
    always_comb begin
        state_nxt_s = state_r;
        wait_nxt_s  = wait_r;
        if (!b_valid_s || grant_b_s) begin
            wait_nxt_s = 4'd0;
        end else if (grant_a_s) begin
            wait_nxt_s = wait_r + 4'd1;
        end else begin
            wait_nxt_s = wait_r;
        end
        case (state_r)
            NORMAL: begin
                if (grant_a_s && b_valid_s && (wait_r == 4'(MAX_WAIT - 1))) begin
                    state_nxt_s = FAVOR_B;
                end else begin
                    state_nxt_s = NORMAL;
                end
            end
            FAVOR_B: begin
                if (grant_b_s) begin
                    state_nxt_s = NORMAL;
                end else begin
                    state_nxt_s = FAVOR_B;
                end
            end
            default: state_nxt_s = NORMAL;
        endcase
    end

    // Write port: x0 entries are consumed silently with the port left idle.
    always_comb begin
        WRITE     = 1'b0;
        INADDRESS = '0;
        IN        = '0;
        if (grant_b_s && (b_addr_s != '0)) begin
            WRITE     = 1'b1;
            INADDRESS = b_addr_s;
            IN        = b_data_s;
        end else if (grant_a_s && (a_addr_s != '0)) begin
            WRITE     = 1'b1;
            INADDRESS = a_addr_s;
            IN        = a_data_s;
        end else begin
            WRITE     = 1'b0;
            INADDRESS = '0;
            IN        = '0;
        end
    end

`ifdef RWARB_BYPASS_EN
    // A is always written after B, so its value is the newer one.
    always_comb begin
        RD_HIT  = 1'b0;
        RD_DATA = '0;
        if ((RD_ADDR != '0) && a_valid_s && (a_addr_s == RD_ADDR)) begin
            RD_HIT  = 1'b1;
            RD_DATA = a_data_s;
        end else if ((RD_ADDR != '0) && b_valid_s && (b_addr_s == RD_ADDR)) begin
            RD_HIT  = 1'b1;
            RD_DATA = b_data_s;
        end else begin
            RD_HIT  = 1'b0;
            RD_DATA = '0;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench: directed vector table, starvation sequence and random traffic
// against a queue-level reference model plus a mock register file.
module tb_regfile_wr_arbiter;
    import regfile_wr_pkg::*;

    localparam int MAX_WAIT = 4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        A_VALID = 1'b0, B_VALID = 1'b0;
    logic [4:0]  A_ADDR = 5'd0, B_ADDR = 5'd0;
    logic [31:0] A_DATA = 32'd0, B_DATA = 32'd0;
    logic        A_READY, B_READY, WRITE, BUSY;
    logic [4:0]  INADDRESS;
    logic [31:0] IN;
`ifdef RWARB_BYPASS_EN
    logic [4:0]  RD_ADDR = 5'd0;
    logic        RD_HIT;
    logic [31:0] RD_DATA;
`endif

    regfile_wr_arbiter #(.DATA_W(32), .ADDR_W(5), .MAX_WAIT(MAX_WAIT)) dut (
        .CLK(CLK), .RESET(RESET),
`ifdef RWARB_BYPASS_EN
        .RD_ADDR(RD_ADDR), .RD_HIT(RD_HIT), .RD_DATA(RD_DATA),
`endif
        .A_VALID(A_VALID), .A_READY(A_READY), .A_ADDR(A_ADDR), .A_DATA(A_DATA),
        .B_VALID(B_VALID), .B_READY(B_READY), .B_ADDR(B_ADDR), .B_DATA(B_DATA),
        .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    logic [31:0] rf_mock [32] = '{default: 32'd0};
    always @(posedge CLK) begin
        if (!RESET && WRITE) rf_mock[INADDRESS] <= IN;
    end

    // Reference model state: the pending entry per port and B's consecutive losses.
    wb_entry_t   a_q = '0, b_q = '0;
    int          losses = 0;
    logic [31:0] rf_exp [32] = '{default: 32'd0};
    int          n_cmp = 0, n_fail = 0;
    logic        s_wr, s_ar, s_br, s_busy;
    logic [4:0]  s_addr;
    logic [31:0] s_data;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic step(input logic rst, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic bv, input logic [4:0] ba, input logic [31:0] bd);
        logic wa, wb, coll, e_wr, e_ar, e_br, e_busy;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
`ifdef RWARB_BYPASS_EN
        logic        e_hit;
        logic [31:0] e_rd;
`endif
        @(negedge CLK);
        RESET = rst; A_VALID = av; A_ADDR = aa; A_DATA = ad;
        B_VALID = bv; B_ADDR = ba; B_DATA = bd;
        #1;
        coll = a_q.valid && b_q.valid && (a_q.addr == b_q.addr) && (a_q.addr != 5'd0);
        wb = !rst && b_q.valid && (!a_q.valid || coll || (losses >= MAX_WAIT));
        wa = !rst && a_q.valid && !wb;
        e_wr = 1'b0; e_addr = 5'd0; e_data = 32'd0;
        if (wa && a_q.addr != 5'd0) begin e_wr = 1'b1; e_addr = a_q.addr; e_data = a_q.data; end
        if (wb && b_q.addr != 5'd0) begin e_wr = 1'b1; e_addr = b_q.addr; e_data = b_q.data; end
        e_ar = !rst && (!a_q.valid || wa);
        e_br = !rst && (!b_q.valid || wb);
        e_busy = !rst && (a_q.valid || b_q.valid);
        s_wr = WRITE; s_addr = INADDRESS; s_data = IN; s_ar = A_READY; s_br = B_READY; s_busy = BUSY;
        chk("model_write", 32'(s_wr), 32'(e_wr));
        chk("model_inaddress", 32'(s_addr), 32'(e_addr));
        chk("model_in", s_data, e_data);
        chk("model_a_ready", 32'(s_ar), 32'(e_ar));
        chk("model_b_ready", 32'(s_br), 32'(e_br));
        chk("model_busy", 32'(s_busy), 32'(e_busy));
`ifdef RWARB_BYPASS_EN
        e_hit = 1'b0; e_rd = 32'd0;
        if (RD_ADDR != 5'd0 && a_q.valid && a_q.addr == RD_ADDR) begin e_hit = 1'b1; e_rd = a_q.data; end
        else if (RD_ADDR != 5'd0 && b_q.valid && b_q.addr == RD_ADDR) begin e_hit = 1'b1; e_rd = b_q.data; end
        chk("model_rd_hit", 32'(RD_HIT), 32'(e_hit));
        chk("model_rd_data", RD_DATA, e_rd);
`endif
        @(posedge CLK);
        if (rst) begin
            a_q = '0; b_q = '0; losses = 0;
        end else begin
            if (e_wr) rf_exp[e_addr] = e_data;
            if (!b_q.valid || wb) losses = 0;
            else if (wa) losses++;
            if (av && e_ar) a_q = '{1'b1, aa, ad}; else if (wa) a_q.valid = 1'b0;
            if (bv && e_br) b_q = '{1'b1, ba, bd}; else if (wb) b_q.valid = 1'b0;
        end
    endtask

    typedef struct {
        logic rst; logic av; logic [4:0] aa; logic [31:0] ad;
        logic bv; logic [4:0] ba; logic [31:0] bd;
        logic wr; logic [4:0] addr; logic [31:0] data; logic ar; logic br; logic busy;
    } vec_t;

    vec_t vecs [14];
    int   got;

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 5'd3, 32'd77,  1'b0, 5'd0, 32'd0,   1'b0, 5'd0, 32'd0,   1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 5'd3, 32'd77,  1'b0, 5'd0, 32'd0,   1'b0, 5'd0, 32'd0,   1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 5'd0, 32'd0,   1'b0, 5'd0, 32'd0,   1'b0, 5'd0, 32'd0,   1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 5'd2, 32'd95,  1'b0, 5'd0, 32'd0,   1'b0, 5'd0, 32'd0,   1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 5'd0, 32'd0,   1'b0, 5'd0, 32'd0,   1'b1, 5'd2, 32'd95,  1'b1, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 5'd1, 32'd28,  1'b1, 5'd6, 32'd108, 1'b0, 5'd0, 32'd0,   1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 5'd0, 32'd0,   1'b0, 5'd0, 32'd0,   1'b1, 5'd1, 32'd28,  1'b1, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 5'd0, 32'd0,   1'b0, 5'd0, 32'd0,   1'b1, 5'd6, 32'd108, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 5'd5, 32'd15,  1'b1, 5'd5, 32'd50,  1'b0, 5'd0, 32'd0,   1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 5'd0, 32'd0,   1'b0, 5'd0, 32'd0,   1'b1, 5'd5, 32'd50,  1'b0, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 5'd0, 32'd0,   1'b0, 5'd0, 32'd0,   1'b1, 5'd5, 32'd15,  1'b1, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 5'd0, 32'd123, 1'b0, 5'd0, 32'd0,   1'b0, 5'd0, 32'd0,   1'b1, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 5'd0, 32'd0,   1'b0, 5'd0, 32'd0,   1'b0, 5'd0, 32'd0,   1'b1, 1'b1, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 5'd0, 32'd0,   1'b0, 5'd0, 32'd0,   1'b0, 5'd0, 32'd0,   1'b1, 1'b1, 1'b0};

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].rst, vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].bv, vecs[i].ba, vecs[i].bd);
            chk($sformatf("vec%0d_write", i), 32'(s_wr), 32'(vecs[i].wr));
            chk($sformatf("vec%0d_inaddress", i), 32'(s_addr), 32'(vecs[i].addr));
            chk($sformatf("vec%0d_in", i), s_data, vecs[i].data);
            chk($sformatf("vec%0d_a_ready", i), 32'(s_ar), 32'(vecs[i].ar));
            chk($sformatf("vec%0d_b_ready", i), 32'(s_br), 32'(vecs[i].br));
            chk($sformatf("vec%0d_busy", i), 32'(s_busy), 32'(vecs[i].busy));
        end
        #2;
        chk("rf_x3_untouched", rf_mock[3], 32'd0);
        chk("rf_x2", rf_mock[2], 32'd95);
        chk("rf_x1", rf_mock[1], 32'd28);
        chk("rf_x6", rf_mock[6], 32'd108);
        chk("rf_x5_collision_final", rf_mock[5], 32'd15);
        chk("rf_x0_untouched", rf_mock[0], 32'd0);

        // Starvation: A streams every cycle while B waits with x4=6.
        step(1'b0, 1'b1, 5'd10, 32'd0, 1'b1, 5'd4, 32'd6);
        got = -1;
        for (int i = 1; i < 20 && got < 0; i++) begin
            step(1'b0, 1'b1, 5'(10 + i), 32'(i), 1'b0, 5'd0, 32'd0);
            if (s_wr && s_addr == 5'd4) begin
                got = i;
                chk("starve_b_data", s_data, 32'd6);
                chk("starve_a_blocked", 32'(s_ar), 32'd0);
            end
        end
        chk("starve_grant_cycle", 32'(got), 32'd5);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("starve_a_resumes_addr", 32'(s_addr), 32'd14);
        chk("starve_a_resumes_write", 32'(s_wr), 32'd1);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // Reset while both buffers hold entries: nothing may be written.
        step(1'b0, 1'b1, 5'd9, 32'd900, 1'b1, 5'd8, 32'd800);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("reset_mid_write", 32'(s_wr), 32'd0);
        chk("reset_mid_busy", 32'(s_busy), 32'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("reset_mid_discard", 32'(s_busy), 32'd0);
        #2;
        chk("reset_mid_x9", rf_mock[9], 32'd0);

`ifdef RWARB_BYPASS_EN
        RD_ADDR = 5'd7;
        step(1'b0, 1'b1, 5'd7, 32'd9, 1'b0, 5'd0, 32'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("bypass_hit", 32'(RD_HIT), 32'd1);
        chk("bypass_data", RD_DATA, 32'd9);
        step(1'b0, 1'b1, 5'd0, 32'd44, 1'b0, 5'd0, 32'd0);
        RD_ADDR = 5'd0;
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("bypass_x0_nohit", 32'(RD_HIT), 32'd0);
`endif

        for (int i = 0; i < 800; i++) begin
`ifdef RWARB_BYPASS_EN
            RD_ADDR = 5'($urandom_range(0, 7));
`endif
            step(1'($urandom_range(0, 59) == 0),
                 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom);
        end
        #2;
        for (int r = 0; r < 32; r++) chk($sformatf("final_rf_x%0d", r), rf_mock[r], rf_exp[r]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
